// File: rtl/temporal_mxu_flex.sv
// Temporal matrix unit: rate-coded A streamed against binary B, C = A x B.
// Each K-step lasts max(1, largest |A| in the column) cycles.
//
// state | meaning
// IDLE  | ready for an operand set
// RUN   | streaming unary A pulses into the accumulators
// DONE  | result held on out until out_ready
module temporal_mxu_flex #(
  parameter int M         = 4,
  parameter int K         = 4,
  parameter int N         = 4,
  parameter int BIT_WIDTH = 4,
  parameter int ACC_WIDTH = 2*BIT_WIDTH + $clog2(K),
  parameter int CYC_W     = 16
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      signed_mode,
  input  logic [M-1:0][K-1:0][BIT_WIDTH-1:0]        A,
  input  logic [K-1:0][N-1:0][BIT_WIDTH-1:0]        B,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [M-1:0][N-1:0][ACC_WIDTH-1:0]        out,
  output logic [CYC_W-1:0]                          run_cycles
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                               state_q, state_d;
  logic [KW-1:0]                        k_q, k_d;
  logic [BIT_WIDTH-1:0]                 c_q, c_d;
  logic [CYC_W-1:0]                     cyc_q, cyc_d;
  logic [CYC_W-1:0]                     run_cycles_q, run_cycles_d;
  logic [M-1:0][K-1:0][BIT_WIDTH-1:0]   a_q, a_d;
  logic [K-1:0][N-1:0][BIT_WIDTH-1:0]   b_q, b_d;
  logic                                 smode_q, smode_d;
  logic [M-1:0][N-1:0][ACC_WIDTH-1:0]   acc_q, acc_d;

  logic [M-1:0][BIT_WIDTH-1:0]          mag;
  logic [M-1:0]                         neg;
  logic [BIT_WIDTH-1:0]                 mag_max;
  logic [N-1:0][ACC_WIDTH-1:0]          bext;
  logic                                 step_end;
  logic [CYC_W-1:0]                     cyc_inc;

  // Negating -2^(BW-1) yields 2^(BW-1), which is exact when read as unsigned.
  always_comb begin
    mag_max = '0;
    for (int i = 0; i < M; i++) begin
      neg[i] = smode_q & a_q[i][k_q][BIT_WIDTH-1];
      mag[i] = neg[i] ? -a_q[i][k_q] : a_q[i][k_q];
      if (mag[i] > mag_max) mag_max = mag[i];
    end
    for (int j = 0; j < N; j++) begin
      bext[j] = smode_q
        ? {{(ACC_WIDTH-BIT_WIDTH){b_q[k_q][j][BIT_WIDTH-1]}}, b_q[k_q][j]}
        : {{(ACC_WIDTH-BIT_WIDTH){1'b0}}, b_q[k_q][j]};
    end
    step_end = (mag_max == '0) || (c_q == mag_max - BIT_WIDTH'(1));
    cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    c_d          = c_q;
    cyc_d        = cyc_q;
    run_cycles_d = run_cycles_q;
    a_d          = a_q;
    b_d          = b_q;
    smode_d      = smode_q;
    acc_d        = acc_q;
    in_ready     = (state_q == IDLE);
    out_valid    = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          smode_d = signed_mode;
          acc_d   = '0;
          k_d     = '0;
          c_d     = '0;
          cyc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < M; i++) begin
          if (c_q < mag[i]) begin
            for (int j = 0; j < N; j++) begin
              acc_d[i][j] = neg[i] ? acc_q[i][j] - bext[j] : acc_q[i][j] + bext[j];
            end
          end
        end
        cyc_d = cyc_inc;
        if (step_end) begin
          c_d = '0;
          if (k_q == KW'(K-1)) begin
            k_d          = '0;
            run_cycles_d = cyc_inc;
            state_d      = DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          c_d = c_q + BIT_WIDTH'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      c_q          <= '0;
      cyc_q        <= '0;
      run_cycles_q <= '0;
      a_q          <= '0;
      b_q          <= '0;
      smode_q      <= 1'b0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      c_q          <= c_d;
      cyc_q        <= cyc_d;
      run_cycles_q <= run_cycles_d;
      a_q          <= a_d;
      b_q          <= b_d;
      smode_q      <= smode_d;
      acc_q        <= acc_d;
    end
  end

  assign out        = acc_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_temporal_mxu_flex.sv
// Scoreboard bench for temporal_mxu_flex: driver pushes model results at
// acceptance, a negedge monitor compares whenever out_valid is presented.
module tb_temporal_mxu_flex;

  localparam int M     = 2;
  localparam int K     = 2;
  localparam int N     = 2;
  localparam int BW    = 4;
  localparam int ACC   = 2*BW + $clog2(K);
  localparam int CYC_W = 16;

  typedef logic [M-1:0][K-1:0][BW-1:0]  a_t;
  typedef logic [K-1:0][N-1:0][BW-1:0]  b_t;
  typedef logic [M-1:0][N-1:0][ACC-1:0] c_t;
  typedef struct {
    c_t               res;
    logic [CYC_W-1:0] rc;
    int               vcyc;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic             signed_mode;
  a_t               A;
  b_t               B;
  logic             out_valid;
  logic             out_ready;
  c_t               out;
  logic [CYC_W-1:0] run_cycles;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   prev_valid = 0;
  bit   rand_bp = 0;

  temporal_mxu_flex #(
    .M(M), .K(K), .N(N), .BIT_WIDTH(BW), .ACC_WIDTH(ACC), .CYC_W(CYC_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .signed_mode(signed_mode),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .run_cycles (run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int opv(input logic [BW-1:0] v, input bit sm);
    return sm ? int'($signed(v)) : int'(v);
  endfunction

  // Reference: plain integer matrix product, step length from column magnitudes.
  function automatic exp_t model(input a_t a, input b_t b, input bit sm, input int c0);
    exp_t e;
    int   r = 0;
    for (int k = 0; k < K; k++) begin
      int mx = 0;
      for (int i = 0; i < M; i++) begin
        int v = opv(a[i][k], sm);
        if (v < 0) v = -v;
        if (v > mx) mx = v;
      end
      r += (mx == 0) ? 1 : mx;
    end
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < K; k++) s += opv(a[i][k], sm) * opv(b[k][j], sm);
        e.res[i][j] = s[ACC-1:0];
      end
    end
    e.rc   = CYC_W'(r);
    e.vcyc = c0 + r + 1;
    return e;
  endfunction

  function automatic a_t mk(input int x00, input int x01, input int x10, input int x11);
    a_t r;
    r[0][0] = x00[BW-1:0];
    r[0][1] = x01[BW-1:0];
    r[1][0] = x10[BW-1:0];
    r[1][1] = x11[BW-1:0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out_valid: got out_valid=1, expected no pending job");
        end else begin
          if (!prev_valid) check("latency", cyc, sbq[0].vcyc);
          check("out", {28'd0, out}, {28'd0, sbq[0].res});
          if (out_ready) begin
            check("run_cycles", {48'd0, run_cycles}, {48'd0, sbq[0].rc});
            void'(sbq.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  // Presents an operand set, records the expected result at the acceptance edge.
  task automatic issue(input a_t a, input b_t b, input bit sm);
    bit acc = 0;
    int c0  = 0;
    int g   = 0;
    A = a; B = b; signed_mode = sm; in_valid = 1'b1;
    while (!acc && g < 100) begin
      @(negedge clk);
      acc = in_ready;
      c0  = cyc;
      g++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready=0, expected acceptance within 100 cycles");
    end else begin
      sbq.push_back(model(a, b, sm, c0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = a_t'($urandom);
    B = b_t'($urandom);
    signed_mode = 1'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_job(input a_t a, input b_t b, input bit sm);
    issue(a, b, sm);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_t a2;
    b_t b2;
    int g;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; signed_mode = 1'b0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out", {28'd0, out}, 64'd0);
    check("rst_run_cycles", {48'd0, run_cycles}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_job(mk(1, 0, 0, 1), b_t'(mk(1, 2, 3, 4)), 1'b1);
    run_job(mk(0, 0, 0, 0), b_t'(mk(7, 7, 7, 7)), 1'b1);
    run_job(mk(-8, 0, 0, -8), b_t'(mk(7, -1, 2, 3)), 1'b1);
    run_job(mk(15, 15, 15, 15), b_t'(mk(15, 15, 15, 15)), 1'b0);
    run_job(mk(15, 15, 15, 15), b_t'(mk(15, 15, 15, 15)), 1'b1);

    // Backpressure in DONE with in_valid asserted; second job waits for IDLE.
    out_ready = 1'b0;
    issue(mk(3, -2, 5, 1), b_t'(mk(-4, 6, 2, -7)), 1'b1);
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("bp_reached_done", {63'd0, out_valid}, 64'd1);
    a2 = mk(6, 1, 2, 9);
    b2 = b_t'(mk(3, 11, 0, 5));
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      A = a2; B = b2; signed_mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check("bp_out_valid_held", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_out_valid", {63'd0, out_valid}, 64'd0);
    check("bp_idle_in_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready) sbq.push_back(model(a2, b2, 1'b0, cyc));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset in the middle of RUN abandons the job.
    issue(mk(-8, 0, 0, -8), b_t'(mk(7, -1, 2, 3)), 1'b1);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out", {28'd0, out}, 64'd0);
    check("midrst_run_cycles", {48'd0, run_cycles}, 64'd0);
    sbq.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_job(mk(-8, 0, 0, -8), b_t'(mk(7, -1, 2, 3)), 1'b1);

    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      run_job(a_t'($urandom), b_t'($urandom), 1'($urandom));
    end
    rand_bp = 1'b0;
    #2;
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/temporal_mxu_flex.md
# temporal_mxu_flex

Parametrised successor to the fixed-square temporal matrix unit. Computes C = A×B for an M×K by K×N matrix pair using unary (rate-coded) A streaming against binary B, with signed/unsigned mode selection. Each K-step lasts only as many cycles as the largest |A| magnitude in that column, with a minimum of one cycle, instead of a fixed 2^BIT_WIDTH. Valid/ready handshakes on input and output make it usable as a pipeline stage between operand buffers and the result writeback.

## Interface
Parameters:
- M, 4: rows of A and of C
- K, 4: columns of A, rows of B (reduction depth)
- N, 4: columns of B and of C
- BIT_WIDTH, 4: operand width
- ACC_WIDTH, 2*BIT_WIDTH+$clog2(K): accumulator/output width; arithmetic wraps modulo 2^ACC_WIDTH
- CYC_W, 16: width of the cycle-count report

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set presented
- in_ready  out  1  block can accept operands
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- A  in  [M][K][BIT_WIDTH]  left matrix
- B  in  [K][N][BIT_WIDTH]  right matrix
- out_valid  out  1  result held on out
- out_ready  in  1  consumer accepts result
- out  out  [M][N][ACC_WIDTH]  result matrix, signed when signed_mode was 1
- run_cycles  out  CYC_W  number of RUN cycles used by the last completed job; saturates at all-ones

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register A, B and signed_mode, clear all accumulators, clear k, c and the cycle counter, then go to RUN.
- Magnitude of A[i][k]: signed mode uses |A|, including −2^(BW−1) → 2^(BW−1), which fits in BW bits unsigned, and sign = MSB. Unsigned mode uses the raw value, with sign=0.
- mag_max_k = max over i of the magnitude of column k, computed combinationally from the registered A.
- B extension: signed mode sign-extends B[k][j] to ACC_WIDTH; unsigned mode zero-extends it.
- RUN, each cycle:
  - pulse_i = (c < mag(A[i][k])).
  - For every i,j with pulse_i: acc[i][j] += sign_i ? −Bext[k][j] : +Bext[k][j].
  - Step end: if mag_max_k==0, or c==mag_max_k−1, set c←0 and k←k+1. Otherwise c←c+1.
  - The cycle counter increments every RUN cycle.
  - Step end with k==K−1: go to DONE and latch run_cycles.
- DONE: out_valid=1. out and run_cycles are stable; in_ready=0. On out_ready, go to IDLE (out_valid falls next cycle).
- in_valid is ignored outside IDLE. A, B and signed_mode may change freely after acceptance.
- out is driven directly by the accumulators. It is defined only while out_valid=1.

## Timing
- Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, out=0, run_cycles=0, k=c=0. Assertion mid-RUN or mid-DONE aborts the job with no result.
- Latency: acceptance edge T. RUN occupies T+1 … T+R, where R = Σ_k max(1, mag_max_k). out_valid=1 from cycle T+R+1.
- Bounds: minimum R=K (all-zero A). Maximum R = K·2^(BW−1) in signed mode, or K·(2^BW−1) in unsigned mode.
- Throughput: one job per R+2 cycles at best (accept, R RUN, 1 DONE with out_ready=1). No overlap between jobs.
- Simultaneous out_ready and a new in_valid in DONE: the new job is not accepted that cycle. It can be accepted on the following IDLE cycle.

## Test plan
- Identity, signed, M=K=N=2, BW=4: A=[[1,0],[0,1]], B=[[1,2],[3,4]] → out=[[1,2],[3,4]], run_cycles=2, out_valid at T+3.
- All-zero A, B=[[7,7],[7,7]] → out all 0, run_cycles=2 (zero columns cost one cycle each).
- Signed negatives: A=[[−8,0],[0,−8]], B=[[7,−1],[2,3]] → out=[[−56,8],[−16,−24]], run_cycles=16.
- Unsigned extremes, ACC_WIDTH=9: A and B all 15, signed_mode=0 → every out=450, run_cycles=30. Repeat with signed_mode=1 (15 is −1) → every out=2, run_cycles=2.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid → out_valid stays 1, out stable, in_ready=0, no job accepted. Then out_ready=1 → IDLE next cycle, next job accepted one cycle later.
- Reset mid-RUN: assert reset_n=0 during the signed-negative case → out=0, out_valid=0, in_ready=1 immediately. The next job runs correctly from scratch.
